apb3_master_bridge: RTL and testbench

APB3 requester that converts a simple valid/ready command stream into APB3 transfers toward up to 16 completers, and returns each transfer's result on a valid/ready response stream. It drives the PADDR/PWDATA/PSEL/PWRITE/PENABLE bus that apb_monitor_assert_if checks, and consumes PRDATA/PREADY/PSLVERR. Its bus output must never fire a monitor assertion except on the documented timeout abort.

---
 rtl/apb3_master_bridge.sv | 127 ++++++++++++
 tb/tb_apb3_master_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb3_master_bridge
// Brief    : valid/ready command stream to APB3 requester with timeout and
//            decode-error responses.
// Revision : 1.0
// ============================================================================
module apb3_master_bridge #(
    parameter int NUM_SLAVES     = 16,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_slverr,
    output logic        rsp_timeout,
    output logic        rsp_decerr,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic [15:0] PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [4:0] c_num_slaves = 5'(NUM_SLAVES);
    localparam logic [7:0] c_tmo_last   = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0] r_state;
    logic [7:0] r_wait;
    logic [3:0] w_idx;
    logic       w_idx_ok;

    assign w_idx     = cmd_addr[SEL_LSB+3:SEL_LSB];
    assign w_idx_ok  = {1'b0, w_idx} < c_num_slaves;
    assign cmd_ready = (r_state == S_IDLE) && !PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            PSEL        <= '0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_decerr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_idx_ok) begin
                            r_state <= S_SETUP;
                            r_wait  <= '0;
                            PSEL    <= 16'd1 << w_idx;
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PWDATA  <= cmd_write ? cmd_wdata : 32'd0;
                        end else begin
                            // Unpopulated completer: answer without touching the bus
                            r_state    <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_slverr <= 1'b1;
                            rsp_decerr <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_state    <= S_RESP;
                        PSEL       <= '0;
                        PENABLE    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_slverr <= PSLVERR;
                        rsp_rdata  <= (!PWRITE && !PSLVERR) ? PRDATA : 32'd0;
                    end else if (r_wait == c_tmo_last) begin
                        // Abort without handshake; the completer never answered
                        r_state     <= S_RESP;
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        rsp_valid   <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b0;
                        rsp_timeout <= 1'b0;
                        rsp_decerr  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb3_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb3_master_bridge
// Brief    : table-driven and randomized checks of apb3_master_bridge.
// Revision : 1.0
// ============================================================================
module tb_apb3_master_bridge;

    localparam int NS  = 12;
    localparam int TMO = 8;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr, rsp_timeout, rsp_decerr;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PENABLE, PREADY, PSLVERR;
    logic [15:0] PSEL;

    always #5 PCLK = ~PCLK;

    apb3_master_bridge #(.NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .rsp_decerr(rsp_decerr),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nwait;   // ACCESS cycles with PREADY low; >= TMO means never ready
        logic        slverr;
        logic [31:0] prdata;
        int          hold;    // response cycles with rsp_ready low
        logic [15:0] e_psel;
        int          e_lat;
        int          e_pcyc;
        int          e_ecyc;
        logic        e_err;
        logic        e_tmo;
        logic        e_dec;
        logic [31:0] e_rdata;
    } vec_t;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_paddr, exp_pwdata;
    logic        exp_pwrite;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input int nwait, input logic slverr, input logic [31:0] prdata,
                                input int hold, input logic [15:0] e_psel, input int e_lat,
                                input int e_pcyc, input int e_ecyc, input logic e_err,
                                input logic e_tmo, input logic e_dec, input logic [31:0] e_rdata);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.nwait = nwait; v.slverr = slverr;
        v.prdata = prdata; v.hold = hold; v.e_psel = e_psel; v.e_lat = e_lat;
        v.e_pcyc = e_pcyc; v.e_ecyc = e_ecyc; v.e_err = e_err; v.e_tmo = e_tmo;
        v.e_dec = e_dec; v.e_rdata = e_rdata;
        return v;
    endfunction

    // Transaction-level expectations derived from the bridge's rules
    function automatic vec_t model(input vec_t v);
        int idx;
        bit dec, tmo;
        idx       = int'(v.addr[15:12]);
        dec       = idx >= NS;
        tmo       = !dec && (v.nwait >= TMO);
        v.e_dec   = dec;
        v.e_tmo   = tmo;
        v.e_psel  = dec ? 16'd0 : 16'(1 << idx);
        v.e_lat   = dec ? 1 : (tmo ? TMO + 2 : v.nwait + 3);
        v.e_pcyc  = dec ? 0 : (tmo ? TMO + 1 : v.nwait + 2);
        v.e_ecyc  = dec ? 0 : (tmo ? TMO : v.nwait + 1);
        v.e_err   = dec || tmo || v.slverr;
        v.e_rdata = (!v.wr && !v.e_err) ? v.prdata : 32'd0;
        return v;
    endfunction

    function automatic bit bus_bad();
        return (PADDR !== exp_paddr) || (PWRITE !== exp_pwrite) || (PWDATA !== exp_pwdata);
    endfunction

    // Entered and left on a negedge with the bridge idle
    task automatic run(input vec_t v, input string tag);
        int          k, pcyc, ecyc, viol, acc;
        bit          done;
        logic [31:0] r_rd;
        logic        r_e, r_t, r_d;
        check({tag, " cmd_ready idle"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        if (!v.e_dec) begin
            exp_paddr = v.addr; exp_pwrite = v.wr; exp_pwdata = v.wr ? v.wdata : 32'd0;
        end
        k = 0; pcyc = 0; ecyc = 0; viol = 0; acc = 0; done = 0;
        while (!done && k < 400) begin
            @(negedge PCLK);
            k++;
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
            if (cmd_ready) viol++;
            if (PSEL != 16'd0) begin
                pcyc++;
                if (PSEL != v.e_psel) viol++;
            end
            if (PENABLE) begin
                ecyc++;
                if (PSEL == 16'd0) viol++;
            end
            if (bus_bad()) viol++;
            if (rsp_valid) done = 1;
            else if (PENABLE) begin
                PREADY  = (acc == v.nwait);
                acc++;
                PSLVERR = PREADY ? v.slverr : 1'($urandom);
                PRDATA  = PREADY ? v.prdata : $urandom;
            end else begin
                PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
            end
        end
        check({tag, " response seen"}, 64'(done), 64'(1));
        check({tag, " latency"}, 64'(k), 64'(v.e_lat));
        check({tag, " PSEL cycles"}, 64'(pcyc), 64'(v.e_pcyc));
        check({tag, " PENABLE cycles"}, 64'(ecyc), 64'(v.e_ecyc));
        check({tag, " rsp_slverr"}, 64'(rsp_slverr), 64'(v.e_err));
        check({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.e_tmo));
        check({tag, " rsp_decerr"}, 64'(rsp_decerr), 64'(v.e_dec));
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.e_rdata));
        r_rd = rsp_rdata; r_e = rsp_slverr; r_t = rsp_timeout; r_d = rsp_decerr;
        rsp_ready = (v.hold == 0);
        for (int h = 1; h <= v.hold; h++) begin
            @(negedge PCLK);
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
            if (!rsp_valid || rsp_rdata !== r_rd || rsp_slverr !== r_e || rsp_timeout !== r_t ||
                rsp_decerr !== r_d || cmd_ready || PSEL != 16'd0 || PENABLE || bus_bad()) viol++;
            if (h == v.hold) rsp_ready = 1'b1;
        end
        @(negedge PCLK);
        rsp_ready = 1'b0;
        check({tag, " protocol/stability"}, 64'(viol), 64'(0));
        check({tag, " back to idle"},
              {59'd0, rsp_valid, cmd_ready, rsp_slverr, rsp_timeout, rsp_decerr}, 64'b01000);
        check({tag, " rdata cleared"}, 64'(rsp_rdata), 64'(0));
        check({tag, " bus idle"}, 64'(bus_bad()) | 64'(PSEL) | 64'(PENABLE), 64'(0));
    endtask

    vec_t tbl[9];
    vec_t rv;
    int   viol;

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;

        //          wr    addr           wdata          nw   se    prdata         hd  psel      lat pc ec err tmo dec rdata
        tbl[0] = mk(1'b1, 32'h0000_3010, 32'hDEAD_BEEF, 0,   1'b0, 32'h0,         0, 16'h0008, 3,  2, 1, 0,  0,  0,  32'h0);
        tbl[1] = mk(1'b0, 32'h0000_5000, 32'h0,         4,   1'b0, 32'h1234_5678, 0, 16'h0020, 7,  6, 5, 0,  0,  0,  32'h1234_5678);
        tbl[2] = mk(1'b0, 32'h0000_1004, 32'h0,         0,   1'b1, 32'hAAAA_5555, 0, 16'h0002, 3,  2, 1, 1,  0,  0,  32'h0);
        tbl[3] = mk(1'b0, 32'h0000_1004, 32'h0,         0,   1'b1, 32'hAAAA_5555, 5, 16'h0002, 3,  2, 1, 1,  0,  0,  32'h0);
        tbl[4] = mk(1'b1, 32'h0000_2000, 32'h0BAD_F00D, 255, 1'b0, 32'h0,         1, 16'h0004, 10, 9, 8, 1,  1,  0,  32'h0);
        tbl[5] = mk(1'b0, 32'h0000_E000, 32'h0,         0,   1'b0, 32'h5555_AAAA, 0, 16'h0000, 1,  0, 0, 1,  0,  1,  32'h0);
        tbl[6] = mk(1'b0, 32'h0000_B0FC, 32'h0,         1,   1'b0, 32'hCAFE_F00D, 2, 16'h0800, 4,  3, 2, 0,  0,  0,  32'hCAFE_F00D);
        tbl[7] = mk(1'b0, 32'h8000_3000, 32'h0,         7,   1'b0, 32'h0F0F_0F0F, 0, 16'h0008, 10, 9, 8, 0,  0,  0,  32'h0F0F_0F0F);
        tbl[8] = mk(1'b1, 32'h0000_F000, 32'h1111_2222, 0,   1'b0, 32'h0,         0, 16'h0000, 1,  0, 0, 1,  0,  1,  32'h0);

        repeat (3) @(negedge PCLK);
        check("reset cmd_ready", 64'(cmd_ready), 64'(0));
        check("reset bus", {PADDR, PWDATA}, 64'(0));
        check("reset ctrl", {45'd0, PSEL, PENABLE, PWRITE, rsp_valid}, 64'(0));
        check("reset rsp", {29'd0, rsp_rdata, rsp_slverr, rsp_timeout, rsp_decerr}, 64'(0));
        PRESET = 1'b0;
        @(negedge PCLK);

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 40; n++) begin
            rv.wr     = 1'($urandom);
            rv.addr   = {$urandom_range(0, 65535), 4'($urandom_range(0, 15)), 12'($urandom)};
            rv.wdata  = $urandom;
            rv.nwait  = $urandom_range(0, 9);
            if (rv.nwait == 9) rv.nwait = 255;
            rv.slverr = ($urandom_range(0, 3) == 0);
            rv.prdata = $urandom;
            rv.hold   = $urandom_range(0, 2);
            run(model(rv), $sformatf("rnd%0d", n));
        end

        // Reset in the middle of an ACCESS phase
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_4000; cmd_wdata = 32'h7777_8888;
        PREADY = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("midreset in ACCESS", {62'd0, PENABLE, PSEL[4]}, 64'b11);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("midreset drop", {46'd0, PSEL, PENABLE, rsp_valid}, 64'(0));
        PRESET = 1'b0;
        exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;
        viol = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (rsp_valid || !cmd_ready || PSEL != 16'd0 || bus_bad()) viol++;
        end
        check("midreset no response", 64'(viol), 64'(0));
        rv.wr = 1'b0; rv.addr = 32'h0000_9008; rv.wdata = '0; rv.nwait = 2; rv.slverr = 1'b0;
        rv.prdata = 32'hFEED_0001; rv.hold = 0;
        run(model(rv), "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire
